// File: rtl/i2s_pkg.sv
// Shared definitions for the stereo I2S transmitter: frame-word layout,
// frame-position counter width and parameter legality checks.
package i2s_pkg;

  localparam int unsigned MAX_SLOT_W   = 32;
  localparam int unsigned DEF_SLOT_W   = 16;
  localparam int unsigned DEF_P_W      = $clog2(2 * DEF_SLOT_W);

  typedef logic [MAX_SLOT_W-1:0]   sample_t;
  typedef logic [2*MAX_SLOT_W-1:0] frame_t;

  function automatic int unsigned cnt_width(input int unsigned slot_w);
    return $clog2(2 * slot_w);
  endfunction

  function automatic bit params_ok(input int unsigned sample_w,
                                   input int unsigned slot_w,
                                   input int unsigned sclk_div);
    return (sample_w >= 2) && (slot_w >= sample_w) &&
           (slot_w <= MAX_SLOT_W) && (sclk_div >= 2);
  endfunction

  // Samples arrive zero-extended; each is left-justified in its slot so the
  // padding bits past sample_w go out as zeros after the sample.
  function automatic frame_t frame_word(input sample_t     left,
                                        input sample_t     right,
                                        input int unsigned sample_w,
                                        input int unsigned slot_w);
    frame_t l_part;
    frame_t r_part;
    l_part = frame_t'(left)  << (2 * slot_w - sample_w);
    r_part = frame_t'(right) << (slot_w - sample_w);
    return l_part | r_part;
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock generator: divides clk48m into sclk and flags the cycle on which
// sclk falls so the serialiser can update in the same register update.
module i2s_sclk_gen #(
  parameter int unsigned SCLK_DIV = 16
) (
  input  logic clk48m,
  input  logic rst_n,
  output logic sclk,
  output logic fall
);

  localparam int unsigned   DW       = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          term;

  assign term = (div_cnt == DIV_LAST);
  assign fall = term && sclk;

  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Parametrised stereo Philips-I2S transmitter with a one-entry holding register.
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence (and forget the last pair) on underrun.
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 16,
  parameter int unsigned SCLK_DIV = 16
) (
  input  logic                clk48m,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                underrun,
  output logic                sclk,
  output logic                lrclk,
  output logic                dout
);

  localparam int unsigned   FW      = 2 * SLOT_W;
  localparam int unsigned   PW      = cnt_width(SLOT_W);
  localparam logic [PW-1:0] P_LAST  = PW'(FW - 1);
  localparam logic [PW-1:0] P_LOAD  = PW'(1);
  localparam logic [PW-1:0] P_RIGHT = PW'(SLOT_W);

  if (!params_ok(SAMPLE_W, SLOT_W, SCLK_DIV)) begin : g_param_check
    $error("i2s_tx_stereo: illegal SAMPLE_W/SLOT_W/SCLK_DIV combination");
  end

  logic                fall;
  logic [PW-1:0]       p;
  logic [PW-1:0]       p_next;
  logic [FW-1:0]       sr;
  logic [FW-1:0]       frame;
  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic                hold_full;

  i2s_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk48m (clk48m),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .fall   (fall)
  );

  // Holding data is kept after a load, so it doubles as the last-sent pair.
  assign p_next   = (p == P_LAST) ? '0 : p + PW'(1);
  assign frame    = FW'(frame_word(sample_t'(hold_l), sample_t'(hold_r), SAMPLE_W, SLOT_W));
  assign in_ready = !hold_full;
  assign dout     = sr[FW-1];

  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      p         <= P_LAST;
      lrclk     <= 1'b1;
      sr        <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall) begin
        p     <= p_next;
        lrclk <= (p_next >= P_RIGHT);
        if (p_next == P_LOAD) begin
          if (hold_full) begin
            sr        <= frame;
            hold_full <= 1'b0;
          end else begin
            underrun <= 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            sr     <= '0;
            hold_l <= '0;
            hold_r <= '0;
`else
            sr <= frame;
`endif
          end
        end else begin
          sr <= {sr[FW-2:0], 1'b0};
        end
      end
      // Placed after the load so a pair arriving on a muting underrun survives.
      if (in_valid && !hold_full) begin
        hold_l    <= in_left;
        hold_r    <= in_right;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Directed bench for i2s_tx_stereo: a default instance and a SLOT_W=24,
// SCLK_DIV=2 instance, checked against hand-computed frames.
module tb_i2s_tx_stereo;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  logic [15:0] a_l, a_r, b_l, b_r;
  logic a_valid, a_ready, a_under, a_sclk, a_lrclk, a_dout;
  logic b_valid, b_ready, b_under, b_sclk, b_lrclk, b_dout;

  i2s_tx_stereo u_a (
    .clk48m(clk), .rst_n(rst_n), .in_left(a_l), .in_right(a_r),
    .in_valid(a_valid), .in_ready(a_ready), .underrun(a_under),
    .sclk(a_sclk), .lrclk(a_lrclk), .dout(a_dout)
  );

  i2s_tx_stereo #(.SAMPLE_W(16), .SLOT_W(24), .SCLK_DIV(2)) u_b (
    .clk48m(clk), .rst_n(rst_n), .in_left(b_l), .in_right(b_r),
    .in_valid(b_valid), .in_ready(b_ready), .underrun(b_under),
    .sclk(b_sclk), .lrclk(b_lrclk), .dout(b_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Capture {lrclk, dout} at every sclk rise, sampled on the falling clk edge.
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  int   ucnt_a;
  logic a_sclk_q, b_sclk_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      ucnt_a   = 0;
      a_sclk_q = 1'b0;
    end else begin
      if (a_sclk && !a_sclk_q) qa.push_back({a_lrclk, a_dout});
      if (a_under) ucnt_a++;
      a_sclk_q = a_sclk;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      b_sclk_q = 1'b0;
    end else begin
      if (b_sclk && !b_sclk_q) qb.push_back({b_lrclk, b_dout});
      b_sclk_q = b_sclk;
    end
  end

  typedef struct {
    bit          send;
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] word;
    bit          under;
  } vec_t;

  vec_t tab[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send_a(input logic [15:0] l, input logic [15:0] r);
    int waited;
    waited  = 0;
    a_l     = l;
    a_r     = r;
    a_valid = 1'b1;
    while (!a_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready_wait", 64'(a_ready), 64'd1);
    @(negedge clk);
    a_valid = 1'b0;
    check("send_taken", 64'(a_ready), 64'd0);
  endtask

  // Frame f of the default instance: rises 32f+2 .. 32f+33 (p=1..31, then next p=0).
  task automatic word_a(input int f, output logic [31:0] d, output logic [31:0] lr);
    int base;
    base = 32 * f + 2;
    d  = '0;
    lr = '0;
    if (qa.size() < base + 32) begin
      check("capture_a_len", 64'(qa.size()), 64'(base + 32));
      return;
    end
    for (int j = 0; j < 32; j++) begin
      d[31-j]  = qa[base+j][0];
      lr[31-j] = qa[base+j][1];
    end
  endtask

  task automatic word_b(output logic [47:0] d, output logic [47:0] lr);
    d  = '0;
    lr = '0;
    if (qb.size() < 50) begin
      check("capture_b_len", 64'(qb.size()), 64'd50);
      return;
    end
    for (int j = 0; j < 48; j++) begin
      d[47-j]  = qb[2+j][0];
      lr[47-j] = qb[2+j][1];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pat;
    logic [31:0] d, lr;
    logic [47:0] db, lrb;

    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    a_valid  = 1'b0; a_l = '0; a_r = '0;
    b_valid  = 1'b0; b_l = '0; b_r = '0;

    tab[0] = '{1'b1, 16'hA5C3, 16'h0F0F, 32'hA5C3_0F0F, 1'b0};
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    tab[1] = '{1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};
`else
    tab[1] = '{1'b0, 16'h0000, 16'h0000, 32'hA5C3_0F0F, 1'b1};
`endif
    tab[2] = '{1'b1, 16'h8001, 16'h7FFE, 32'h8001_7FFE, 1'b0};
    tab[3] = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_0001, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_a", 64'({a_sclk, a_lrclk, a_dout, a_ready, a_under}), 64'(5'b01010));
    check("reset_b", 64'({b_sclk, b_lrclk, b_dout, b_ready, b_under}), 64'(5'b01010));
    rst_n = 1'b1;

    // Held-valid pair sequence on A, one frame on B.
    a_l = 16'h1111; a_r = 16'h2222; a_valid = 1'b1;
    b_l = 16'hFFFF; b_r = 16'hA5C3; b_valid = 1'b1;
    to_cyc(1);
    check("held_first_taken", 64'(a_ready), 64'd0);
    check("b_taken", 64'(b_ready), 64'd0);
    b_valid = 1'b0;
    a_l = 16'h3333; a_r = 16'h4444;
    pat = '0;
    for (int c = 1; c <= 8; c++) begin
      to_cyc(c);
      pat = {pat[6:0], b_sclk};
    end
    check("b_sclk_period", 64'(pat), 64'h66);
    pat = '0;
    to_cyc(15); pat = {pat[6:0], a_sclk};
    to_cyc(16); pat = {pat[6:0], a_sclk};
    to_cyc(31); pat = {pat[6:0], a_sclk, a_lrclk};
    to_cyc(32); pat = {pat[6:0], a_sclk, a_lrclk};
    check("a_sclk_lrclk_start", 64'(pat[5:0]), 64'(6'b011100));
    to_cyc(63);
    check("held_wait_ready", 64'(a_ready), 64'd0);
    to_cyc(64);
    check("held_ready_at_load", 64'(a_ready), 64'd1);
    check("held_no_underrun", 64'(a_under), 64'd0);
    to_cyc(65);
    check("held_second_taken", 64'(a_ready), 64'd0);
    a_valid = 1'b0;
    to_cyc(210);
    word_b(db, lrb);
    check("b_word", 64'(db), 64'h0000_FFFF_00A5_C300);
    check("b_lrclk", 64'(lrb), 64'h0000_0000_01FF_FFFE);
    to_cyc(1090);
    check("held_underrun_count", 64'(ucnt_a), 64'd0);
    to_cyc(2100);
    word_a(0, d, lr);
    check("held_word0", 64'(d), 64'h1111_2222);
    check("held_lrclk0", 64'(lr), 64'h0001_FFFE);
    word_a(1, d, lr);
    check("held_word1", 64'(d), 64'h3333_4444);

    // Table-driven frames on A.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 4; f++) begin
      to_cyc(1024 * f - 36);
      if (tab[f].send) send_a(tab[f].l, tab[f].r);
      to_cyc(64 + 1024 * f);
      check($sformatf("tab%0d_underrun", f), 64'(a_under), 64'(tab[f].under));
    end
    to_cyc(4150);
    for (int f = 0; f < 4; f++) begin
      word_a(f, d, lr);
      check($sformatf("tab%0d_word", f), 64'(d), 64'(tab[f].word));
      check($sformatf("tab%0d_lrclk", f), 64'(lr), 64'h0001_FFFE);
    end
    check("tab_underrun_total", 64'(ucnt_a), 64'd1);

    // Asynchronous reset in the middle of a right slot.
    to_cyc(4810);
    send_a(16'h5A5A, 16'h5A5A);
    to_cyc(4820);
    check("pre_reset_state", 64'({a_sclk, a_lrclk, a_ready}), 64'(3'b110));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'({a_sclk, a_lrclk, a_dout, a_ready, a_under}), 64'(5'b01010));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pat = '0;
    to_cyc(31); pat = {pat[6:0], a_lrclk};
    to_cyc(32); pat = {pat[6:0], a_lrclk};
    check("restart_lrclk", 64'(pat[1:0]), 64'(2'b10));
    pat = '0;
    to_cyc(64); pat = {pat[6:0], a_under};
    to_cyc(65); pat = {pat[6:0], a_under};
    check("restart_underrun", 64'(pat[1:0]), 64'(2'b10));
    to_cyc(1080);
    word_a(0, d, lr);
    check("restart_word", 64'(d), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
